// File: rtl/passcode_entry_ctrl.sv
// passcode_entry_ctrl: keypad sequencing controller.
//
// Sits behind the 10-key priority encoder. Key presses are edge detected and
// shifted into an entry buffer. On ENTER the buffer is compared against the
// stored secret. Consecutive failures are counted and raise the alarm after
// MAX_ATTEMPTS.
//
// Optional feature, selected by macro ENTRY_TIMEOUT_EN: a partial entry that
// sees no digit for TIMEOUT_CYCLES cycles is discarded. Without the macro no
// timer is built and a partial entry is held indefinitely.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   key_code       encoder output, bit4 = valid, [3:0] = BCD digit
//   enter          submit request (level, rising edge detected)
//   clear_in       discard partial entry (level, rising edge detected)
//   relock         leave UNLOCKED (level, rising edge detected)
//   alarm_reset    leave ALARM (level, rising edge detected)
//   secret_code    stored passcode, first digit in the MSB nibble
//   entered_code   entry buffer, most recent digit in the LSB nibble
//   digit_count    digits currently held
//   attempt_count  consecutive failed attempts
//   unlocked       high while UNLOCKED
//   alarm          high while in ALARM
//   disp_code      {1'b1, last digit} when digits are held, else 5'b00000
module passcode_entry_ctrl #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              key_code,
    input  logic                    enter,
    input  logic                    clear_in,
    input  logic                    relock,
    input  logic                    alarm_reset,
    input  logic [4*NUM_DIGITS-1:0] secret_code,
    output logic [4*NUM_DIGITS-1:0] entered_code,
    output logic [3:0]              digit_count,
    output logic [3:0]              attempt_count,
    output logic                    unlocked,
    output logic                    alarm,
    output logic [4:0]              disp_code
);

    localparam int unsigned BufW = 4 * NUM_DIGITS;

    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15 || NUM_DIGITS < 2 || NUM_DIGITS > 15 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("passcode_entry_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StCheck,
        StUnlocked,
        StAlarm
    } state_e;

    state_e state_q;

    // Previous-cycle copies of the level inputs for rising-edge detection
    logic key_valid_q, enter_q, clear_q, relock_q, alarm_reset_q;

    logic key_evt, digit_evt, enter_evt, clear_evt, relock_evt, alarm_reset_evt;
    logic buf_full, code_match;

    assign key_evt         = key_code[4] & ~key_valid_q;
    assign digit_evt       = key_evt && (key_code[3:0] <= 4'd9);
    assign enter_evt       = enter & ~enter_q;
    assign clear_evt       = clear_in & ~clear_q;
    assign relock_evt      = relock & ~relock_q;
    assign alarm_reset_evt = alarm_reset & ~alarm_reset_q;

    assign buf_full   = (digit_count == 4'(NUM_DIGITS));
    assign code_match = buf_full && (entered_code == secret_code);

    assign disp_code = (digit_count != 4'd0) ? {1'b1, entered_code[3:0]} : 5'b00000;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);

    logic [TmrW-1:0] tmr_q;
    logic            timeout_hit;

    assign timeout_hit = (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));

    // Counts idle cycles in ENTRY; any digit press restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else if (state_q != StEntry || digit_evt) begin
            tmr_q <= '0;
        end else if (!timeout_hit) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            entered_code  <= '0;
            digit_count   <= '0;
            attempt_count <= '0;
            unlocked      <= 1'b0;
            alarm         <= 1'b0;
            key_valid_q   <= 1'b0;
            enter_q       <= 1'b0;
            clear_q       <= 1'b0;
            relock_q      <= 1'b0;
            alarm_reset_q <= 1'b0;
        end else begin
            key_valid_q   <= key_code[4];
            enter_q       <= enter;
            clear_q       <= clear_in;
            relock_q      <= relock;
            alarm_reset_q <= alarm_reset;

            case (state_q)
                StIdle, StEntry: begin
                    // Priority: clear > enter > digit
                    if (clear_evt) begin
                        entered_code <= '0;
                        digit_count  <= '0;
                        state_q      <= StIdle;
                    end else if (enter_evt) begin
                        state_q <= StCheck;
                    end else if (digit_evt) begin
                        if (!buf_full) begin
                            entered_code <= {entered_code[BufW-5:0], key_code[3:0]};
                            digit_count  <= digit_count + 4'd1;
                            state_q      <= StEntry;
                        end
`ifdef ENTRY_TIMEOUT_EN
                    end else if (state_q == StEntry && timeout_hit) begin
                        entered_code <= '0;
                        digit_count  <= '0;
                        state_q      <= StIdle;
`endif
                    end
                end

                StCheck: begin
                    entered_code <= '0;
                    digit_count  <= '0;
                    if (code_match) begin
                        attempt_count <= '0;
                        unlocked      <= 1'b1;
                        state_q       <= StUnlocked;
                    end else begin
                        attempt_count <= attempt_count + 4'd1;
                        if ((attempt_count + 4'd1) == 4'(MAX_ATTEMPTS)) begin
                            alarm   <= 1'b1;
                            state_q <= StAlarm;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end

                StUnlocked: begin
                    if (relock_evt) begin
                        unlocked <= 1'b0;
                        state_q  <= StIdle;
                    end
                end

                StAlarm: begin
                    if (alarm_reset_evt) begin
                        attempt_count <= '0;
                        alarm         <= 1'b0;
                        state_q       <= StIdle;
                    end
                end

                default: begin
                    unlocked <= 1'b0;
                    alarm    <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule
